// File: rtl/bsk_mgr_cut_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : bsk_mgr_cut_rd_sched (with bsk_mgr_common_param_pkg)
// Description : BSK cut read scheduler. Accepts one batch command at a time
//               and expands it into ordered per-cut read requests, for each
//               iteration cut 0..BSK_CUT_NB-1. Each request is gated by a
//               per-cut credit counter that mirrors free downstream slots.
//               A one-cycle completion pulse follows the last read.
// Ports       : clk, a_rst_n          clock, async active-low reset
//               cmd_vld/cmd_rdy       batch command handshake
//               cmd_iter_nb, cmd_bid  iterations minus one, batch id
//               rd_vld/rd_rdy         read request handshake
//               rd_cut_id, rd_iter,   request fields
//               rd_bid, rd_last
//               credit_rtn            per-cut slot-freed pulse
//               batch_done(_bid)      completion pulse and its batch id
//               err_credit_ovf        sticky credit overflow flag
// Revision    : 1.0 - initial release
// ============================================================================

package bsk_mgr_common_param_pkg;
  parameter int BSK_CUT_NB = 1;
endpackage

module bsk_mgr_cut_rd_sched #(
  parameter  int BSK_CUT_NB = bsk_mgr_common_param_pkg::BSK_CUT_NB,
  parameter  int ITER_W     = 8,
  parameter  int BID_W      = 4,
  parameter  int CREDIT_NB  = 4,
  localparam int CUT_W      = $clog2((BSK_CUT_NB > 2) ? BSK_CUT_NB : 2)
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [ITER_W-1:0]     cmd_iter_nb,
  input  logic [BID_W-1:0]      cmd_bid,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [CUT_W-1:0]      rd_cut_id,
  output logic [ITER_W-1:0]     rd_iter,
  output logic [BID_W-1:0]      rd_bid,
  output logic                  rd_last,
  input  logic [BSK_CUT_NB-1:0] credit_rtn,
  output logic                  batch_done,
  output logic [BID_W-1:0]      batch_done_bid,
  output logic                  err_credit_ovf
);

  localparam int                CRD_W        = $clog2(CREDIT_NB + 1);
  localparam logic [CUT_W-1:0]  C_CUT_LAST   = CUT_W'(BSK_CUT_NB - 1);
  localparam logic [CRD_W-1:0]  C_CRD_FULL   = CRD_W'(CREDIT_NB);
  localparam logic              C_SINGLE_CUT = (BSK_CUT_NB == 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_cmd_rdy;
  logic [CUT_W-1:0]    r_cut;
  logic [ITER_W-1:0]   r_iter;
  logic [ITER_W-1:0]   r_iter_nb;
  logic [BID_W-1:0]    r_bid;
  logic                r_last;
  logic                r_batch_done;
  logic [BID_W-1:0]    r_done_bid;
  logic                r_err_ovf;

  logic [BSK_CUT_NB-1:0] w_crd_avail;
  logic [BSK_CUT_NB-1:0] w_ovf;
  logic                  w_cur_avail;
  logic                  w_rd_hs;
  logic                  w_cmd_hs;
  logic                  w_cut_wrap;
  logic [CUT_W-1:0]      w_cut_nxt;
  logic [ITER_W-1:0]     w_iter_nxt;

  // Credit availability of the currently addressed cut.
  always_comb begin
    w_cur_avail = 1'b0;
    for (int i = 0; i < BSK_CUT_NB; i++) begin
      if (r_cut == CUT_W'(i)) begin
        w_cur_avail = w_crd_avail[i];
      end
    end
  end

  assign rd_vld     = (r_state == ST_RUN) & w_cur_avail;
  assign w_rd_hs    = rd_vld & rd_rdy;
  assign w_cmd_hs   = cmd_vld & r_cmd_rdy;
  assign w_cut_wrap = (r_cut == C_CUT_LAST);
  assign w_cut_nxt  = w_cut_wrap ? '0 : r_cut + CUT_W'(1);
  assign w_iter_nxt = w_cut_wrap ? r_iter + ITER_W'(1) : r_iter;

  // Per-cut credit counters. A consume and a return in the same cycle
  // cancel; a return into a full counter is dropped and flagged.
  for (genvar gi = 0; gi < BSK_CUT_NB; gi++) begin : g_credit
    logic [CRD_W-1:0] r_credit;
    logic             w_take;
    logic             w_full;

    assign w_take          = w_rd_hs & (r_cut == CUT_W'(gi));
    assign w_full          = (r_credit == C_CRD_FULL);
    assign w_crd_avail[gi] = (r_credit != '0);
    assign w_ovf[gi]       = credit_rtn[gi] & ~w_take & w_full;

    always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
        r_credit <= C_CRD_FULL;
      end else if (w_take & ~credit_rtn[gi]) begin
        r_credit <= r_credit - CRD_W'(1);
      end else if (~w_take & credit_rtn[gi] & ~w_full) begin
        r_credit <= r_credit + CRD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_err_ovf <= 1'b0;
    end else if (|w_ovf) begin
      r_err_ovf <= 1'b1;
    end
  end

  // Batch sequencer. rd_last is precomputed for the next request so that
  // it is register-driven alongside the other request fields.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state      <= ST_IDLE;
      r_cmd_rdy    <= 1'b1;
      r_cut        <= '0;
      r_iter       <= '0;
      r_iter_nb    <= '0;
      r_bid        <= '0;
      r_last       <= 1'b0;
      r_batch_done <= 1'b0;
      r_done_bid   <= '0;
    end else begin
      r_batch_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs) begin
            r_state   <= ST_RUN;
            r_cmd_rdy <= 1'b0;
            r_iter_nb <= cmd_iter_nb;
            r_bid     <= cmd_bid;
            r_cut     <= '0;
            r_iter    <= '0;
            r_last    <= (cmd_iter_nb == '0) & C_SINGLE_CUT;
          end
        end
        ST_RUN: begin
          if (w_rd_hs) begin
            if (r_last) begin
              // Counters are not advanced past the last request, so an
              // all-ones iteration count never wraps.
              r_state      <= ST_IDLE;
              r_cmd_rdy    <= 1'b1;
              r_batch_done <= 1'b1;
              r_done_bid   <= r_bid;
              r_last       <= 1'b0;
              r_cut        <= '0;
              r_iter       <= '0;
            end else begin
              r_cut  <= w_cut_nxt;
              r_iter <= w_iter_nxt;
              r_last <= (w_iter_nxt == r_iter_nb) & (w_cut_nxt == C_CUT_LAST);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cmd_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_rdy        = r_cmd_rdy;
  assign rd_cut_id      = r_cut;
  assign rd_iter        = r_iter;
  assign rd_bid         = r_bid;
  assign rd_last        = r_last;
  assign batch_done     = r_batch_done;
  assign batch_done_bid = r_done_bid;
  assign err_credit_ovf = r_err_ovf;

endmodule

`default_nettype wire

// File: doc/bsk_mgr_cut_rd_sched.md
# bsk_mgr_cut_rd_sched

Read scheduler for the bootstrapping-key (BSK) cut storage inside the BSK manager. It accepts one batch read command at a time and expands it into an ordered stream of per-cut read requests: for each iteration, cut 0 through cut BSK_CUT_NB-1. Issue is gated by per-cut credits that reflect free slots in the downstream per-cut buffers. When the last read of a batch is accepted, the block reports completion.

## Interface
Parameters:
- BSK_CUT_NB, default from bsk_mgr_common_param_pkg (1): number of BSK cuts; any value ≥1 is legal.
- ITER_W, default 8: width of the iteration count field.
- BID_W, default 4: width of the batch identifier.
- CREDIT_NB, default 4: credits per cut (downstream buffer depth); ≥1.
- CUT_W, derived: $clog2(max(2,BSK_CUT_NB)).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  batch command valid
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy
- cmd_iter_nb  in  ITER_W  iterations minus one (0 → 1 iteration)
- cmd_bid  in  BID_W  batch id
- rd_vld  out  1  read request valid
- rd_rdy  in  1  read request accepted
- rd_cut_id  out  CUT_W  cut addressed
- rd_iter  out  ITER_W  iteration index
- rd_bid  out  BID_W  batch id of the request
- rd_last  out  1  last request of the batch
- credit_rtn  in  BSK_CUT_NB  one-cycle pulse per cut: one slot freed
- batch_done  out  1  one-cycle completion pulse
- batch_done_bid  out  BID_W  id of the completed batch, valid with batch_done
- err_credit_ovf  out  1  sticky: a credit was returned to a full counter

## Operation
- FSM with two states: IDLE and RUN. Reset enters IDLE.
- IDLE:
  - cmd_rdy=1.
  - On a command handshake, latch cmd_iter_nb and cmd_bid, set iter=0 and cut=0, and move to RUN.
- RUN:
  - cmd_rdy=0.
  - rd_vld = (credit[cut] != 0).
  - rd_cut_id=cut, rd_iter=iter, rd_bid=latched id.
  - rd_last = (iter==iter_nb) & (cut==BSK_CUT_NB-1).
- Advancing on each rd handshake:
  - If cut < BSK_CUT_NB-1, increment cut.
  - Otherwise set cut=0 and increment iter.
  - On rd_last, move to IDLE and pulse batch_done on the next cycle, with batch_done_bid = latched id.
- Credits:
  - One counter per cut, width $clog2(CREDIT_NB+1), reset to CREDIT_NB.
  - A handshake on cut c decrements credit[c].
  - credit_rtn[c] increments credit[c].
  - A simultaneous handshake and return on the same cut leaves the counter unchanged.
  - A return while the counter equals CREDIT_NB (with no same-cycle consumption) does not change the counter and sets err_credit_ovf. The flag clears only on reset.
- Credits persist across batches and are never reset by the FSM.
- rd_* fields stay stable while rd_vld & !rd_rdy. rd_vld cannot drop without a handshake, because credit only decreases on a handshake.
- iter_nb = 2^ITER_W-1 is legal. Counters must not wrap before rd_last.

## Timing
- Reset values:
  - cmd_rdy=1, rd_vld=0, rd_cut_id=0, rd_iter=0, rd_bid=0, rd_last=0.
  - batch_done=0, batch_done_bid=0, err_credit_ovf=0.
  - All credits = CREDIT_NB, state IDLE.
- Command accepted at cycle T → RUN at T+1; rd_vld at T+1 if credit[0] > 0.
- Throughput is one read per cycle while credits last and rd_rdy=1.
- A credit return at cycle t on a starved cut → rd_vld at t+1.
- Last handshake at cycle T → batch_done=1 and cmd_rdy=1 at T+1. A new command can be accepted at T+1, giving its first read at T+2.
- Asserting a_rst_n low mid-batch aborts immediately:
  - All outputs return to their reset values.
  - The in-flight batch produces no batch_done.
- rd_vld is combinational from state and the credit register. All other outputs are register-driven.

## Test plan
- BSK_CUT_NB=1, CREDIT_NB=4, cmd_iter_nb=2, bid=5, rd_rdy=1, no returns → rd_iter 0,1,2 issued on consecutive cycles T+1..T+3, rd_last at T+3, batch_done with bid 5 at T+4, final credit=1.
- BSK_CUT_NB=1, CREDIT_NB=4, cmd_iter_nb=7, no returns → exactly 4 reads, then rd_vld=0. Pulse credit_rtn at t → one read at t+1. Deliver 4 returns in total → batch completes with 8 reads.
- BSK_CUT_NB=3, cmd_iter_nb=1 → request order (cut,iter) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1). rd_last only on (2,1).
- rd_rdy toggled randomly (e.g. 0,0,1,0,1) → rd_* fields stable while stalled, and no request is lost or duplicated.
- Credit overflow and same-cycle events:
  - credit_rtn while a counter is at 4 → err_credit_ovf=1, counter stays 4.
  - Handshake and return on the same cut in the same cycle → counter unchanged.
- Reset mid-batch (after 2 of 6 reads) → rd_vld=0 and cmd_rdy=1 immediately, credits back at 4, no batch_done. A new command then runs from iter 0.
